wor_bus_arb: RTL and testbench

WOR_BUS_ARB -- requirements
Module: wor_bus_arb

---
 rtl/wor_bus_arb.sv | 161 ++++++++++++++++
 tb/tb_wor_bus_arb.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wor_bus_arb.sv
`default_nettype none
// ============================================================================
//  Module   : wor_bus_arb
//  Purpose  : Round-robin arbiter for NREQ requesters sharing a wired-OR bus.
//             A winner owns the bus for a burst of blen+1 beats. The burst
//             ends early (abort) if the winner drops its request. Each burst
//             is followed by one idle turnaround cycle, so two different
//             drivers never hold the net in adjacent cycles.
//  Ports    : clk     - clock, rising edge
//             rst     - asynchronous active-high reset
//             req     - per-requester level request
//             blen    - per-requester burst length field (beats = field+1)
//             wdat    - per-requester write data, slice i for requester i
//             bus_rdy - downstream accepts the current beat
//             gnt     - one-hot grant (or zero)
//             bus_vld - beat valid on bus_dat
//             bus_dat - data of the granted requester, zero otherwise
//             done    - one-cycle pulse on burst completion
//             abort   - one-cycle pulse on burst abandonment
//             busy    - arbiter not idle
//  Revision : 1.0 - initial release
// ============================================================================
module wor_bus_arb #(
  parameter int NREQ = 4,
  parameter int DW   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [4*NREQ-1:0]    blen,
  input  logic [DW*NREQ-1:0]   wdat,
  input  logic                 bus_rdy,
  output logic [NREQ-1:0]      gnt,
  output logic                 bus_vld,
  output logic [DW-1:0]        bus_dat,
  output logic [NREQ-1:0]      done,
  output logic [NREQ-1:0]      abort,
  output logic                 busy
);

  localparam int C_IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_XFER = 2'd1,
    S_TURN = 2'd2
  } state_t;

  state_t            r_state;
  logic [C_IW-1:0]   r_ptr;
  logic [C_IW-1:0]   r_win;
  logic [4:0]        r_cnt;
  logic [NREQ-1:0]   r_gnt;
  logic              r_vld;
  logic              r_busy;

  logic              w_found;
  logic [C_IW-1:0]   w_idx;
  logic [C_IW-1:0]   w_pick;
  logic [NREQ-1:0]   w_pick_oh;
  logic [3:0]        w_pick_blen;
  logic [NREQ-1:0]   w_win_oh;
  logic [DW-1:0]     w_dat;
  logic              w_xfer;
  logic              w_req_win;
  logic              w_last;
  logic              w_drop;
  logic [C_IW-1:0]   w_ptr_nxt;

  // Round-robin search: first active request at or above r_ptr, wrapping.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_idx = C_IW'((int'(r_ptr) + k) % NREQ);
      if (!w_found && req[w_idx]) begin
        w_found = 1'b1;
        w_pick  = w_idx;
      end
    end
  end

  // Constant-index muxes keep the slice selects width-clean.
  always_comb begin
    w_pick_oh   = '0;
    w_win_oh    = '0;
    w_pick_blen = '0;
    w_dat       = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_pick_oh[i] = (w_pick == C_IW'(i));
      w_win_oh[i]  = (r_win == C_IW'(i));
      if (w_pick == C_IW'(i)) w_pick_blen = blen[4*i +: 4];
      if (r_win == C_IW'(i))  w_dat       = wdat[DW*i +: DW];
    end
  end

  assign w_xfer    = (r_state == S_XFER);
  assign w_req_win = |(req & w_win_oh);
  // A final beat accepted wins over a simultaneous request drop.
  assign w_last    = w_xfer && bus_rdy && (r_cnt == 5'd1);
  assign w_drop    = w_xfer && !w_req_win && !w_last;
  assign w_ptr_nxt = (r_win == C_IW'(NREQ-1)) ? '0 : r_win + 1'b1;

  // Pulses are decoded from the state register, so reset kills them at once.
  assign done    = w_last ? w_win_oh : '0;
  assign abort   = w_drop ? w_win_oh : '0;
  assign gnt     = r_gnt;
  assign bus_vld = r_vld;
  assign bus_dat = r_vld ? w_dat : '0;
  assign busy    = r_busy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_win   <= '0;
      r_cnt   <= '0;
      r_gnt   <= '0;
      r_vld   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_state <= S_XFER;
            r_win   <= w_pick;
            r_cnt   <= {1'b0, w_pick_blen} + 5'd1;
            r_gnt   <= w_pick_oh;
            r_vld   <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        S_XFER: begin
          if (w_last || w_drop) begin
            // Any beats still outstanding on an abort are simply dropped.
            r_state <= S_TURN;
            r_cnt   <= '0;
            r_gnt   <= '0;
            r_vld   <= 1'b0;
          end else if (bus_rdy) begin
            r_cnt <= r_cnt - 5'd1;
          end
        end
        S_TURN: begin
          r_ptr   <= w_ptr_nxt;
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_gnt   <= '0;
          r_vld   <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_wor_bus_arb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wor_bus_arb
//  Purpose  : Self-checking bench for wor_bus_arb. A transaction-level model
//             (owner / beats left / turnaround flag / pointer) predicts every
//             output each cycle; scenario tasks add targeted checks.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_wor_bus_arb;

  localparam int NREQ = 4;
  localparam int DW   = 8;
  localparam int OW   = 3*NREQ + DW + 2;

  logic                clk;
  logic                rst;
  logic [NREQ-1:0]     req;
  logic [4*NREQ-1:0]   blen;
  logic [DW*NREQ-1:0]  wdat;
  logic                bus_rdy;
  logic [NREQ-1:0]     gnt;
  logic                bus_vld;
  logic [DW-1:0]       bus_dat;
  logic [NREQ-1:0]     done;
  logic [NREQ-1:0]     abort;
  logic                busy;

  logic [OW-1:0]       obs;
  logic [OW-1:0]       e_obs;

  int n_checks;
  int n_fail;

  // Reference model state
  int m_owner;
  int m_left;
  int m_ptr;
  bit m_gap;
  logic [NREQ-1:0] e_gnt, e_done, e_abort;
  logic            e_vld, e_busy;
  logic [DW-1:0]   e_dat;

  wor_bus_arb #(.NREQ(NREQ), .DW(DW)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .blen    (blen),
    .wdat    (wdat),
    .bus_rdy (bus_rdy),
    .gnt     (gnt),
    .bus_vld (bus_vld),
    .bus_dat (bus_dat),
    .done    (done),
    .abort   (abort),
    .busy    (busy)
  );

  assign obs = {gnt, bus_vld, bus_dat, done, abort, busy};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void model_reset();
    m_owner = -1;
    m_left  = 0;
    m_ptr   = 0;
    m_gap   = 1'b0;
  endfunction

  // Expected outputs for the current model state and current inputs.
  function automatic void model_calc();
    e_gnt = '0; e_vld = 1'b0; e_dat = '0; e_done = '0; e_abort = '0; e_busy = 1'b0;
    if (m_owner >= 0) begin
      e_gnt[m_owner] = 1'b1;
      e_vld  = 1'b1;
      e_dat  = wdat[m_owner*DW +: DW];
      e_busy = 1'b1;
      if (bus_rdy && m_left == 1) e_done[m_owner] = 1'b1;
      else if (!req[m_owner])     e_abort[m_owner] = 1'b1;
    end else if (m_gap) begin
      e_busy = 1'b1;
    end
    e_obs = {e_gnt, e_vld, e_dat, e_done, e_abort, e_busy};
  endfunction

  // Advance the model across one rising edge.
  function automatic void model_commit();
    if (m_owner >= 0) begin
      if (e_done != 0 || e_abort != 0) begin
        m_ptr   = (m_owner + 1) % NREQ;
        m_owner = -1;
        m_gap   = 1'b1;
      end else if (bus_rdy) begin
        m_left = m_left - 1;
      end
    end else if (m_gap) begin
      m_gap = 1'b0;
    end else if (req != 0) begin
      for (int k = 0; k < NREQ; k++)
        if (m_owner < 0 && req[(m_ptr + k) % NREQ]) m_owner = (m_ptr + k) % NREQ;
      m_left = int'(blen[m_owner*4 +: 4]) + 1;
    end
  endfunction

  function automatic int oh_index(logic [NREQ-1:0] v);
    int r;
    r = -1;
    for (int i = 0; i < NREQ; i++) if (v[i]) r = i;
    return r;
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    req = '0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    rst = 1'b0; req = '0; blen = '0; wdat = '0; bus_rdy = 1'b0;
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (obs !== '0) begin
      n_fail++;
      $display("FAIL reset_async got=%h exp=%h", obs, {OW{1'b0}});
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int c = 0; c < 3; c++) begin
      #2; model_calc();
      n_checks++;
      if (obs !== e_obs) begin
        n_fail++;
        $display("FAIL reset_idle cyc=%0d got=%h exp=%h", c, obs, e_obs);
      end
      model_commit();
      @(posedge clk); @(negedge clk);
    end
  endtask

  task automatic test_single_burst();
    int gcnt, done_cyc;
    apply_reset();
    blen = 16'h0002; wdat = 32'h44332211; bus_rdy = 1'b1;
    gcnt = 0; done_cyc = -1;
    for (int c = 0; c < 8; c++) begin
      req = (c < 4) ? 4'b0001 : ((c >= 6) ? 4'b0011 : 4'b0000);
      #2; model_calc();
      n_checks++;
      if (obs !== e_obs) begin
        n_fail++;
        $display("FAIL single cyc=%0d got=%h exp=%h", c, obs, e_obs);
      end
      if (c < 6 && gnt === 4'b0001) gcnt++;
      if (done[0] === 1'b1) done_cyc = c;
      if (c == 7) begin
        n_checks++;
        if (gnt !== 4'b0010) begin
          n_fail++;
          $display("FAIL single_ptr got=%b exp=%b", gnt, 4'b0010);
        end
      end
      model_commit();
      @(posedge clk); @(negedge clk);
    end
    n_checks++;
    if (gcnt !== 3) begin
      n_fail++;
      $display("FAIL single_gnt_cycles got=%0d exp=3", gcnt);
    end
    n_checks++;
    if (done_cyc !== 3) begin
      n_fail++;
      $display("FAIL single_done_cycle got=%0d exp=3", done_cyc);
    end
  endtask

  task automatic test_round_robin();
    int order[$];
    int exp_ord[5];
    logic [NREQ-1:0] prev_g;
    exp_ord = '{0, 1, 2, 3, 0};
    apply_reset();
    req = 4'b1111; blen = '0; bus_rdy = 1'b1; wdat = 32'hDDCCBBAA;
    prev_g = '0;
    for (int c = 0; c < 15; c++) begin
      #2; model_calc();
      n_checks++;
      if (obs !== e_obs) begin
        n_fail++;
        $display("FAIL rr cyc=%0d got=%h exp=%h", c, obs, e_obs);
      end
      if (prev_g != 0) begin
        n_checks++;
        if (gnt !== 4'b0000) begin
          n_fail++;
          $display("FAIL rr_gap cyc=%0d got=%b exp=0000", c, gnt);
        end
      end
      if (gnt != 0) order.push_back(oh_index(gnt));
      prev_g = gnt;
      model_commit();
      @(posedge clk); @(negedge clk);
    end
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (i >= order.size() || order[i] !== exp_ord[i]) begin
        n_fail++;
        $display("FAIL rr_order idx=%0d got=%0d exp=%0d", i,
                 (i < order.size()) ? order[i] : -1, exp_ord[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    int beats, xcyc, dcnt;
    logic [DW-1:0] prev_dat;
    bit prev_stall;
    apply_reset();
    blen = 16'h0030; bus_rdy = 1'b0; wdat = 32'h0;
    beats = 0; xcyc = 0; dcnt = 0; prev_stall = 1'b0; prev_dat = '0;
    for (int c = 0; c < 10; c++) begin
      req = (c < 8) ? 4'b0010 : 4'b0000;
      bus_rdy = (c >= 1) && (c % 2 == 1);
      wdat[15:8] = 8'hA0 + 8'(beats);
      #2; model_calc();
      n_checks++;
      if (obs !== e_obs) begin
        n_fail++;
        $display("FAIL bp cyc=%0d got=%h exp=%h", c, obs, e_obs);
      end
      if (prev_stall) begin
        n_checks++;
        if (bus_dat !== prev_dat) begin
          n_fail++;
          $display("FAIL bp_stable cyc=%0d got=%h exp=%h", c, bus_dat, prev_dat);
        end
      end
      if (gnt[1] === 1'b1) xcyc++;
      if (gnt[1] === 1'b1 && bus_vld && bus_rdy) beats++;
      if (done[1] === 1'b1) dcnt++;
      prev_stall = (gnt[1] === 1'b1) && !bus_rdy;
      prev_dat = bus_dat;
      model_commit();
      @(posedge clk); @(negedge clk);
    end
    n_checks++;
    if (beats !== 4) begin n_fail++; $display("FAIL bp_beats got=%0d exp=4", beats); end
    n_checks++;
    if (xcyc !== 7) begin n_fail++; $display("FAIL bp_xfer_cycles got=%0d exp=7", xcyc); end
    n_checks++;
    if (dcnt !== 1) begin n_fail++; $display("FAIL bp_done_count got=%0d exp=1", dcnt); end
  endtask

  task automatic test_abort();
    int ab_cnt, ab_cyc, dn_cnt;
    apply_reset();
    blen = 16'h0300; bus_rdy = 1'b1; wdat = 32'h77665544;
    ab_cnt = 0; ab_cyc = -1; dn_cnt = 0;
    for (int c = 0; c < 6; c++) begin
      req = (c <= 1) ? 4'b0100 : ((c <= 3) ? 4'b0000 : 4'b1111);
      #2; model_calc();
      n_checks++;
      if (obs !== e_obs) begin
        n_fail++;
        $display("FAIL abort cyc=%0d got=%h exp=%h", c, obs, e_obs);
      end
      if (abort[2] === 1'b1) begin ab_cnt++; ab_cyc = c; end
      if (done[2] === 1'b1) dn_cnt++;
      if (c == 5) begin
        n_checks++;
        if (gnt !== 4'b1000) begin
          n_fail++;
          $display("FAIL abort_ptr got=%b exp=%b", gnt, 4'b1000);
        end
      end
      model_commit();
      @(posedge clk); @(negedge clk);
    end
    n_checks++;
    if (ab_cnt !== 1 || ab_cyc !== 2) begin
      n_fail++;
      $display("FAIL abort_pulse got=%0d@%0d exp=1@2", ab_cnt, ab_cyc);
    end
    n_checks++;
    if (dn_cnt !== 0) begin n_fail++; $display("FAIL abort_no_done got=%0d exp=0", dn_cnt); end
  endtask

  task automatic test_drop_on_last();
    apply_reset();
    blen = 16'h0001; bus_rdy = 1'b1; wdat = 32'h0000005A;
    for (int c = 0; c < 4; c++) begin
      req = (c < 2) ? 4'b0001 : 4'b0000;
      #2; model_calc();
      n_checks++;
      if (obs !== e_obs) begin
        n_fail++;
        $display("FAIL droplast cyc=%0d got=%h exp=%h", c, obs, e_obs);
      end
      if (c == 2) begin
        n_checks++;
        if (done !== 4'b0001 || abort !== 4'b0000) begin
          n_fail++;
          $display("FAIL droplast_pulse got=done %b abort %b exp=done 0001 abort 0000", done, abort);
        end
      end
      model_commit();
      @(posedge clk); @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_xfer();
    apply_reset();
    blen = 16'h5000; bus_rdy = 1'b1; wdat = 32'h9E000000; req = 4'b1000;
    for (int c = 0; c < 3; c++) begin
      #2; model_calc();
      n_checks++;
      if (obs !== e_obs) begin
        n_fail++;
        $display("FAIL rstmid cyc=%0d got=%h exp=%h", c, obs, e_obs);
      end
      if (c < 2) begin
        model_commit();
        @(posedge clk); @(negedge clk);
      end
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if (obs !== '0) begin
      n_fail++;
      $display("FAIL rstmid_async got=%h exp=%h", obs, {OW{1'b0}});
    end
    @(posedge clk); #1;
    n_checks++;
    if (obs !== '0) begin
      n_fail++;
      $display("FAIL rstmid_hold got=%h exp=%h", obs, {OW{1'b0}});
    end
    @(negedge clk);
    req = 4'b1111;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int c = 0; c < 2; c++) begin
      #2; model_calc();
      n_checks++;
      if (obs !== e_obs) begin
        n_fail++;
        $display("FAIL rstmid_after cyc=%0d got=%h exp=%h", c, obs, e_obs);
      end
      if (c == 1) begin
        n_checks++;
        if (gnt !== 4'b0001) begin
          n_fail++;
          $display("FAIL rstmid_first got=%b exp=%b", gnt, 4'b0001);
        end
      end
      model_commit();
      @(posedge clk); @(negedge clk);
    end
  endtask

  task automatic test_random();
    logic [NREQ-1:0] prev_g;
    apply_reset();
    req = '0; prev_g = '0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NREQ; i++)
        if ($urandom_range(0, 7) == 0) req[i] = ~req[i];
      blen    = 16'($urandom);
      wdat    = $urandom;
      bus_rdy = ($urandom_range(0, 3) != 0);
      #2; model_calc();
      n_checks++;
      if (obs !== e_obs) begin
        n_fail++;
        $display("FAIL rand cyc=%0d got=%h exp=%h", c, obs, e_obs);
      end
      if (prev_g != 0 && gnt != 0 && gnt != prev_g) begin
        n_checks++;
        n_fail++;
        $display("FAIL rand_adjacent cyc=%0d got=%b exp=0000 after %b", c, gnt, prev_g);
      end
      prev_g = gnt;
      model_commit();
      @(posedge clk); @(negedge clk);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    model_reset();
    test_reset();
    test_single_burst();
    test_round_robin();
    test_backpressure();
    test_abort();
    test_drop_on_last();
    test_reset_mid_xfer();
    test_random();
    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
